// File: rtl/note_sprite_fetch_if.sv
// Lane-side bundle for note_sprite_fetch: control pulses, scan position, sprite ROM port and pixel
// output. The master side drives scan/control/ROM data; the slave side is the fetch engine.
interface note_sprite_fetch_if;
    logic        frame_start;
    logic        note_spawn;
    logic        note_clear;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [23:0] rom_data;
    logic [12:0] rom_addr;
    logic        pixel_on;
    logic [23:0] pixel_rgb;
    logic        note_active;
    logic [9:0]  note_y;
    logic        note_missed;

    modport master (
        output frame_start, note_spawn, note_clear, DrawX, DrawY, rom_data,
        input  rom_addr, pixel_on, pixel_rgb, note_active, note_y, note_missed
    );

    modport slave (
        input  frame_start, note_spawn, note_clear, DrawX, DrawY, rom_data,
        output rom_addr, pixel_on, pixel_rgb, note_active, note_y, note_missed
    );
endinterface

// File: rtl/note_sprite_fetch.sv
// Per-lane falling-note engine: tracks one note's top row per frame, maps the scan position to a
// 64x64 sprite ROM address and emits the keyed ROM pixel two cycles after the scan position.
module note_sprite_fetch #(
    parameter logic [9:0]  LANE_X      = 10'd128,
    parameter logic [9:0]  SPEED       = 10'd4,
    parameter logic [10:0] SCREEN_H    = 11'd480,
    parameter logic [23:0] TRANSPARENT = 24'hFF00FF
) (
    input  logic               Clk,
    input  logic               Reset,
    note_sprite_fetch_if.slave bus
);

    typedef enum logic {StIdle, StFalling} state_e;

    state_e      state_q, state_d;
    logic [9:0]  y_q, y_d;
    logic        missed_q, missed_d;
    logic [10:0] next_y;

    logic [10:0] x11, y11, lane11, top11;
    logic [5:0]  dx, dy;
    logic        hit0, hit1_q, hit2_q;
    logic [12:0] addr_d, addr_q;
    logic        pix_on;

    // Clear is resolved before spawn, and spawn before frame_start.
    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        missed_d = 1'b0;
        next_y   = {1'b0, y_q} + {1'b0, SPEED};
        unique case (state_q)
            StIdle: begin
                if (bus.note_spawn) begin
                    state_d = StFalling;
                    y_d     = '0;
                end
            end
            StFalling: begin
                if (bus.note_clear) begin
                    state_d = bus.note_spawn ? StFalling : StIdle;
                    y_d     = '0;
                end else if (bus.frame_start) begin
                    if (next_y >= SCREEN_H) begin
                        state_d  = StIdle;
                        y_d      = '0;
                        missed_d = 1'b1;
                    end else begin
                        y_d = next_y[9:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Offsets only need their low 6 bits: inside the box they are exact, outside they are unused.
    always_comb begin
        x11    = {1'b0, bus.DrawX};
        y11    = {1'b0, bus.DrawY};
        lane11 = {1'b0, LANE_X};
        top11  = {1'b0, y_q};
        dx     = bus.DrawX[5:0] - LANE_X[5:0];
        dy     = bus.DrawY[5:0] - y_q[5:0];
        hit0   = (state_q == StFalling)
               && (x11 >= lane11) && (x11 < lane11 + 11'd64)
               && (y11 >= top11)  && (y11 < top11 + 11'd64);
        addr_d = hit0 ? {1'b0, dy, dx} : 13'd0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            y_q      <= '0;
            missed_q <= 1'b0;
            addr_q   <= '0;
            hit1_q   <= 1'b0;
            hit2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            missed_q <= missed_d;
            addr_q   <= addr_d;
            hit1_q   <= hit0;
            hit2_q   <= hit1_q;
        end
    end

    // hit2 lines up with the ROM's registered read data.
    always_comb begin
        pix_on = hit2_q && (bus.rom_data != TRANSPARENT);
    end

    assign bus.rom_addr    = addr_q;
    assign bus.pixel_on    = pix_on;
    assign bus.pixel_rgb   = pix_on ? bus.rom_data : 24'h000000;
    assign bus.note_active = (state_q == StFalling);
    assign bus.note_y      = y_q;
    assign bus.note_missed = missed_q;

endmodule

// File: tb/tb_note_sprite_fetch.sv
// Directed bench for note_sprite_fetch with an identity sprite ROM and a behavioural lane model.
module tb_note_sprite_fetch;
    localparam int          LaneX  = 128;
    localparam int          Speed  = 4;
    localparam int          ScrH   = 480;
    localparam logic [23:0] Transp = 24'hFF00FF;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic rom_force = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    note_sprite_fetch_if bif ();

    note_sprite_fetch dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bif)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM: mem[a] = a, 1-cycle registered read; rom_force makes it return the key colour.
    always @(posedge Clk) bif.rom_data <= rom_force ? Transp : {11'd0, bif.rom_addr};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Lane model: note state as integers, pixel expectation as a 2-deep history of scan hits.
    bit          m_active;
    int          m_y;
    bit          m_miss;
    bit          e_hit1, e_hit2;
    logic [12:0] e_addr;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_active <= 1'b0;
            m_y      <= 0;
            m_miss   <= 1'b0;
            e_hit1   <= 1'b0;
            e_hit2   <= 1'b0;
            e_addr   <= '0;
        end else begin
            automatic int  dx, dy, y;
            automatic bit  hit, act, miss;
            dx   = int'(bif.DrawX) - LaneX;
            dy   = int'(bif.DrawY) - m_y;
            hit  = m_active && dx >= 0 && dx < 64 && dy >= 0 && dy < 64;
            act  = m_active;
            y    = m_y;
            miss = 1'b0;
            if (m_active && bif.note_clear) begin
                act = 1'b0;
                y   = 0;
            end
            if (bif.note_spawn && !act) begin
                act = 1'b1;
                y   = 0;
            end else if (bif.frame_start && m_active && !bif.note_clear) begin
                if (y + Speed >= ScrH) begin
                    act  = 1'b0;
                    y    = 0;
                    miss = 1'b1;
                end else begin
                    y = y + Speed;
                end
            end
            m_active <= act;
            m_y      <= y;
            m_miss   <= miss;
            e_hit1   <= hit;
            e_hit2   <= e_hit1;
            e_addr   <= hit ? 13'(dy * 64 + dx) : 13'd0;
        end
    end

    always @(negedge Clk) begin
        automatic bit          exp_on;
        automatic logic [23:0] exp_rgb;
        exp_on  = e_hit2 && (bif.rom_data != Transp);
        exp_rgb = exp_on ? bif.rom_data : 24'h0;
        chk("model_active", 32'(bif.note_active), 32'(m_active));
        chk("model_y", 32'(bif.note_y), 32'(m_y));
        chk("model_missed", 32'(bif.note_missed), 32'(m_miss));
        chk("model_rom_addr", 32'(bif.rom_addr), 32'(e_addr));
        chk("model_pixel_on", 32'(bif.pixel_on), 32'(exp_on));
        chk("model_pixel_rgb", 32'(bif.pixel_rgb), 32'(exp_rgb));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulse(input bit fs, input bit sp, input bit cl);
        bif.frame_start = fs;
        bif.note_spawn  = sp;
        bif.note_clear  = cl;
        cyc(1);
        bif.frame_start = 1'b0;
        bif.note_spawn  = 1'b0;
        bif.note_clear  = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) pulse(1'b1, 1'b0, 1'b0);
    endtask

    task automatic scan(input int x, input int y);
        bif.DrawX = 10'(x);
        bif.DrawY = 10'(y);
    endtask

    initial begin
        bif.frame_start = 1'b0;
        bif.note_spawn  = 1'b0;
        bif.note_clear  = 1'b0;
        scan(0, 0);
        cyc(2);
        Reset = 1'b0;
        cyc(1);
        chk("reset_active", 32'(bif.note_active), 32'd0);
        chk("reset_y", 32'(bif.note_y), 32'd0);

        // frame_start while idle does nothing
        pulse(1'b1, 1'b0, 1'b0);
        chk("idle_frame_active", 32'(bif.note_active), 32'd0);

        pulse(1'b0, 1'b1, 1'b0);
        frames(10);
        chk("fall10_y", 32'(bif.note_y), 32'd40);
        chk("fall10_active", 32'(bif.note_active), 32'd1);

        scan(130, 45);
        cyc(1);
        chk("addr_130_45", 32'(bif.rom_addr), 32'h142);
        cyc(1);
        chk("pix_on_130_45", 32'(bif.pixel_on), 32'd1);
        chk("pix_rgb_130_45", 32'(bif.pixel_rgb), 32'h000142);
        scan(127, 45);
        cyc(2);
        chk("pix_on_x127", 32'(bif.pixel_on), 32'd0);
        scan(192, 45);
        cyc(2);
        chk("pix_on_x192", 32'(bif.pixel_on), 32'd0);
        scan(191, 103);
        cyc(1);
        chk("addr_corner", 32'(bif.rom_addr), 32'hFFF);
        cyc(1);
        chk("pix_rgb_corner", 32'(bif.pixel_rgb), 32'h000FFF);
        scan(191, 104);
        cyc(2);
        chk("pix_on_y104", 32'(bif.pixel_on), 32'd0);

        rom_force = 1'b1;
        scan(130, 45);
        cyc(2);
        chk("key_pix_on", 32'(bif.pixel_on), 32'd0);
        chk("key_pix_rgb", 32'(bif.pixel_rgb), 32'd0);
        rom_force = 1'b0;
        scan(0, 0);
        cyc(2);

        frames(109);
        chk("y_476", 32'(bif.note_y), 32'd476);
        pulse(1'b1, 1'b0, 1'b0);
        chk("miss_pulse", 32'(bif.note_missed), 32'd1);
        chk("miss_active", 32'(bif.note_active), 32'd0);
        chk("miss_y", 32'(bif.note_y), 32'd0);
        cyc(1);
        chk("miss_one_cycle", 32'(bif.note_missed), 32'd0);

        pulse(1'b0, 1'b1, 1'b0);
        frames(119);
        chk("y_476_again", 32'(bif.note_y), 32'd476);
        pulse(1'b1, 1'b0, 1'b1);
        chk("clear_frame_nomiss", 32'(bif.note_missed), 32'd0);
        chk("clear_frame_active", 32'(bif.note_active), 32'd0);
        cyc(1);
        chk("clear_frame_nomiss2", 32'(bif.note_missed), 32'd0);

        pulse(1'b0, 1'b1, 1'b0);
        frames(3);
        pulse(1'b0, 1'b1, 1'b1);
        chk("clr_spawn_active", 32'(bif.note_active), 32'd1);
        chk("clr_spawn_y", 32'(bif.note_y), 32'd0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("clear_idle", 32'(bif.note_active), 32'd0);
        pulse(1'b1, 1'b1, 1'b0);
        chk("spawn_frame_y", 32'(bif.note_y), 32'd0);
        chk("spawn_frame_active", 32'(bif.note_active), 32'd1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("after_spawn_y", 32'(bif.note_y), 32'd4);

        // Reset mid-fall at note_y=200 with the scan inside the sprite
        frames(49);
        chk("y_200", 32'(bif.note_y), 32'd200);
        scan(140, 210);
        cyc(3);
        chk("pre_reset_pix_on", 32'(bif.pixel_on), 32'd1);
        Reset = 1'b1;
        #1;
        chk("rst_active", 32'(bif.note_active), 32'd0);
        chk("rst_y", 32'(bif.note_y), 32'd0);
        chk("rst_missed", 32'(bif.note_missed), 32'd0);
        chk("rst_addr", 32'(bif.rom_addr), 32'd0);
        chk("rst_pix_on", 32'(bif.pixel_on), 32'd0);
        chk("rst_pix_rgb", 32'(bif.pixel_rgb), 32'd0);
        cyc(1);
        Reset = 1'b0;
        frames(2);
        chk("post_rst_missed", 32'(bif.note_missed), 32'd0);
        chk("post_rst_active", 32'(bif.note_active), 32'd0);
        scan(0, 0);
        cyc(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
